// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / event-out bundle of the PS/2 scan-code decoder.
// The reader drives data/data_ready/data_valid, and the consumer drives ev_read.
interface ps2_scancode_decoder_if;
    logic [7:0] data;
    logic       data_ready;
    logic       data_valid;
    logic [7:0] ev_code;
    logic       ev_extended;
    logic       ev_release;
    logic       ev_pause;
    logic       ev_valid;
    logic       ev_read;
    logic       dev_ack;
    logic       dev_resend;
    logic       bat_ok;
    logic       bat_fail;
    logic       kbd_overrun;
    logic       overflow;
    logic [7:0] err_count;

    // Event handshake: the head event transfers on any posedge where ev_valid=1
    // and ev_read=1. The head fields stay stable while ev_valid=1 and ev_read=0.
    // Input bytes have no back-pressure. data_ready is a one-cycle strobe.
    modport master (
        output data, data_ready, data_valid, ev_read,
        input  ev_code, ev_extended, ev_release, ev_pause, ev_valid,
               dev_ack, dev_resend, bat_ok, bat_fail, kbd_overrun,
               overflow, err_count
    );

    modport slave (
        input  data, data_ready, data_valid, ev_read,
        output ev_code, ev_extended, ev_release, ev_pause, ev_valid,
               dev_ack, dev_resend, bat_ok, bat_fail, kbd_overrun,
               overflow, err_count
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Turns PS/2 set-2 scan-code bytes into make/break key events queued in a FWFT FIFO.
// It also decodes keyboard status bytes and counts framing and protocol errors.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    ps2_scancode_decoder_if.slave       bus,
    output logic [2:0]                  o_state
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = 11;

    localparam logic [7:0] B_EXT       = 8'hE0;
    localparam logic [7:0] B_BRK       = 8'hF0;
    localparam logic [7:0] B_PAUSE     = 8'hE1;
    localparam logic [7:0] B_ACK       = 8'hFA;
    localparam logic [7:0] B_RESEND    = 8'hFE;
    localparam logic [7:0] B_BAT_OK    = 8'hAA;
    localparam logic [7:0] B_BAT_FAIL  = 8'hFC;
    localparam logic [7:0] B_OVR_LO    = 8'h00;
    localparam logic [7:0] B_OVR_HI    = 8'hFF;
    localparam logic [7:0] PAUSE_CODE  = 8'h77;
    localparam logic [2:0] PAUSE_SKIP  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_PAUSE   = 3'd4
    } state_t;

    state_t             r_state;
    logic [2:0]         r_skip;
    logic [4:0]         r_status;
    logic [7:0]         r_err_count;
    logic               r_overflow;

    logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_accept;
    logic               w_bad;
    logic               w_is_prefix;
    state_t             w_next_state;
    logic [2:0]         w_next_skip;
    logic               w_push;
    logic [ENT_W-1:0]   w_push_entry;
    logic               w_err;
    logic [4:0]         w_status;

    logic               w_not_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_wr_en;
    logic               w_drop;
    logic [ENT_W-1:0]   w_head;

    assign w_accept    = bus.data_ready & bus.data_valid;
    assign w_bad       = bus.data_ready & ~bus.data_valid;
    assign w_is_prefix = (bus.data == B_EXT) || (bus.data == B_BRK) || (bus.data == B_PAUSE);

    // Sequence decode. Entry layout is {pause, release, extended, code}.
    // w_status is ordered {ack, resend, bat_ok, bat_fail, overrun}.
    always_comb begin
        w_next_state = r_state;
        w_next_skip  = r_skip;
        w_push       = 1'b0;
        w_push_entry = {3'b000, bus.data};
        w_err        = 1'b0;
        w_status     = 5'b00000;
        if (w_bad) begin
            w_next_state = S_IDLE;
            w_next_skip  = 3'd0;
            w_err        = 1'b1;
        end else if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    case (bus.data)
                        B_EXT:      w_next_state = S_EXT;
                        B_BRK:      w_next_state = S_BRK;
                        B_PAUSE: begin
                            w_next_state = S_PAUSE;
                            w_next_skip  = PAUSE_SKIP;
                        end
                        B_ACK:      w_status = 5'b10000;
                        B_RESEND:   w_status = 5'b01000;
                        B_BAT_OK:   w_status = 5'b00100;
                        B_BAT_FAIL: w_status = 5'b00010;
                        B_OVR_LO,
                        B_OVR_HI:   w_status = 5'b00001;
                        default:    w_push   = 1'b1;
                    endcase
                end
                S_EXT: begin
                    w_next_state = S_IDLE;
                    if (bus.data == B_BRK) begin
                        w_next_state = S_EXT_BRK;
                    end else if (w_is_prefix) begin
                        w_err = 1'b1;
                    end else begin
                        w_push       = 1'b1;
                        w_push_entry = {3'b001, bus.data};
                    end
                end
                S_BRK: begin
                    w_next_state = S_IDLE;
                    if (w_is_prefix) begin
                        w_err = 1'b1;
                    end else begin
                        w_push       = 1'b1;
                        w_push_entry = {3'b010, bus.data};
                    end
                end
                S_EXT_BRK: begin
                    w_next_state = S_IDLE;
                    if (w_is_prefix) begin
                        w_err = 1'b1;
                    end else begin
                        w_push       = 1'b1;
                        w_push_entry = {3'b011, bus.data};
                    end
                end
                S_PAUSE: begin
                    // The seven bytes after E1 are fixed, so they are only counted.
                    if (r_skip <= 3'd1) begin
                        w_next_state = S_IDLE;
                        w_next_skip  = 3'd0;
                        w_push       = 1'b1;
                        w_push_entry = {3'b100, PAUSE_CODE};
                    end else begin
                        w_next_skip = r_skip - 3'd1;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_skip  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_skip      <= 3'd0;
            r_status    <= 5'b00000;
            r_err_count <= 8'h00;
        end else begin
            r_state  <= w_next_state;
            r_skip   <= w_next_skip;
            r_status <= w_status;
            if (w_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop       = bus.ev_read & w_not_empty;
    // When the FIFO is full the write slot is the head slot. A pop in the same
    // cycle releases that slot, so the write can go ahead.
    assign w_wr_en     = w_push & (~w_full | w_pop);
    assign w_drop      = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head          = r_mem[r_rd_ptr];
    assign bus.ev_valid    = w_not_empty;
    assign bus.ev_code     = w_not_empty ? w_head[7:0] : 8'h00;
    assign bus.ev_extended = w_not_empty & w_head[8];
    assign bus.ev_release  = w_not_empty & w_head[9];
    assign bus.ev_pause    = w_not_empty & w_head[10];

    assign bus.dev_ack     = r_status[4];
    assign bus.dev_resend  = r_status[3];
    assign bus.bat_ok      = r_status[2];
    assign bus.bat_fail    = r_status[1];
    assign bus.kbd_overrun = r_status[0];
    assign bus.overflow    = r_overflow;
    assign bus.err_count   = r_err_count;

    assign o_state = r_state;
endmodule
